uart_rx: RTL and testbench

- 8N1 UART receiver on the 50 MHz system clock; the receive-side counterpart of the team's UART transmitter.
- Synchronizes the asynchronous RX line, detects the start bit and samples each bit at mid-period.
- Presents the received byte with a sticky rdy flag, which the consumer clears by handshake.
- Used for the command/telemetry link and loopback-tested against the transmitter.

---
 rtl/uart_pkg.sv | 12 +
 rtl/rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 90 +++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding for the receiver and transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: BAUD_CNT (clocks per bit at 50 MHz / 19200 baud), HALF_CNT, state_t.
package uart_pkg;

   localparam logic [11:0] BAUD_CNT = 12'd2604;
   localparam logic [11:0] HALF_CNT = BAUD_CNT >> 1;

   typedef enum logic {IDLE, RECV} state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop preset-high synchronizer for an asynchronous input, plus falling-edge detect.
// Latency: 2 clk to sync_out, fall asserts the same cycle sync_out first reads 0.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), async_in (raw pin),
//        sync_out (synchronized level), fall (1-cycle falling-edge strobe).
module rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic fall
);

   logic meta_q;
   logic prev_q;

   // All flops preset high so an idle-high line never looks like an edge out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= 1'b1;
         sync_out <= 1'b1;
         prev_q   <= 1'b1;
      end else begin
         meta_q   <= async_in;
         sync_out <= meta_q;
         prev_q   <= sync_out;
      end
   end

   assign fall = prev_q & ~sync_out;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit detect, mid-bit sampling, sticky rdy with clr_rdy handshake.
// Latency: rdy rises ~10 bit periods after the start edge (2-3 clk sync + HALF_CNT + 9 bit periods + 1).
// Backpressure: none; an unacknowledged byte is overwritten by the next one (rdy drops at its start).
// Ports: clk, rst_n (async active-low), RX (serial in, idle high), clr_rdy (ack),
//        rx_data[7:0] (last byte), rdy (sticky byte valid), frm_err (stop bit was low).
module uart_rx #(
   parameter logic [11:0] BAUD_CNT = uart_pkg::BAUD_CNT,
   parameter logic [11:0] HALF_CNT = BAUD_CNT >> 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err
);

   import uart_pkg::*;

   logic        rx_s;
   logic        rx_fall;
   state_t      state;
   logic [11:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [8:0]  shift_reg;
   logic        shift;
   logic        set_rdy;
   logic        start;

   rx_sync u_rx_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (RX),
      .sync_out (rx_s),
      .fall     (rx_fall)
   );

   assign start   = (state == IDLE) && rx_fall;
   assign shift   = (state == RECV) && (baud_cnt == 12'd0);
   // Ten shifts cover start, 8 data bits and stop; the start bit has fallen out of shift_reg.
   assign set_rdy = (state == RECV) && (bit_cnt == 4'd10);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud_cnt  <= 12'd0;
         bit_cnt   <= 4'd0;
         shift_reg <= 9'h1FF;
         rx_data   <= 8'h00;
         rdy       <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         // SR flop: a completing byte beats a simultaneous acknowledge.
         if (set_rdy)
            rdy <= 1'b1;
         else if (clr_rdy || start)
            rdy <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_fall) begin
                  baud_cnt <= HALF_CNT;
                  bit_cnt  <= 4'd0;
                  state    <= RECV;
               end
            end
            RECV: begin
               if (set_rdy) begin
                  rx_data <= shift_reg[7:0];
                  frm_err <= ~shift_reg[8];
                  state   <= IDLE;
               end else if (shift) begin
                  // Line already high again at start-bit midpoint: treat as a glitch.
                  if ((bit_cnt == 4'd0) && rx_s) begin
                     state <= IDLE;
                  end else begin
                     shift_reg <= {rx_s, shift_reg[8:1]};
                     baud_cnt  <= BAUD_CNT;
                     bit_cnt   <= bit_cnt + 4'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 12'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a shortened bit period.
// Serial frames are driven from tasks; expected {frm_err, data} go into a queue
// and are compared when rdy rises.
module tb_uart_rx;

   localparam int B    = 64;          // clocks per bit in this bench
   localparam int HALF = B / 2;
   // rdy arrival window after driving the start edge: sync + half bit + 9 bit periods, plus slack.
   localparam int LAT_LO = HALF + 9 * B + 2;
   localparam int LAT_HI = HALF + 9 * B + 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       RX;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frm_err;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         lat_start = 0;
   int         lat;
   logic       lat_chk = 1'b0;
   logic       mon_rdy_q = 1'b0;
   logic       hs_seen;
   logic [8:0] mon_e;
   logic [8:0] exp_q[$];
   logic [7:0] d;

   uart_rx #(.BAUD_CNT(12'(B))) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX      (RX),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      RX = b;
      repeat (B) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v, input logic stop);
      exp_q.push_back({~stop, v});
      lat_start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(v[i]);
      drive_bit(stop);
      RX = 1'b1;
   endtask

   task automatic wait_rdy(input string tag);
      for (int i = 0; i < 4 * B && !rdy; i++) @(negedge clk);
      check(tag, rdy, 1);
   endtask

   task automatic pulse_clr(input string tag);
      @(negedge clk);
      clr_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_rdy = 1'b0;
      check(tag, rdy, 0);
   endtask

   // Scoreboard: compare on every rising edge of rdy.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rdy && !mon_rdy_q) begin
            if (exp_q.size() == 0) begin
               check("spurious_rdy", rdy, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rx_data", rx_data, mon_e[7:0]);
               check("frm_err", frm_err, mon_e[8]);
               if (lat_chk) begin
                  lat = cyc - lat_start;
                  check("latency_in_window", (lat >= LAT_LO) && (lat <= LAT_HI), 1);
                  lat_chk = 1'b0;
               end
            end
         end
         mon_rdy_q = rdy;
      end
   end

   initial begin
      #(20 * 100000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      RX      = 1'b1;
      clr_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rdy", rdy, 0);
      check("rst_frm_err", frm_err, 0);
      rst_n = 1'b1;
      idle(8);

      // Single bytes, acknowledged after each.
      lat_chk = 1'b1;
      send_byte(8'hA5, 1'b1);
      wait_rdy("rdy_a5");
      pulse_clr("clr_a5");
      idle(B);
      send_byte(8'h00, 1'b1);
      wait_rdy("rdy_00");
      pulse_clr("clr_00");
      idle(B);
      send_byte(8'hFF, 1'b1);
      wait_rdy("rdy_ff");
      pulse_clr("clr_ff");
      idle(B);

      // Back-to-back with no ack: second start drops rdy, old data held until completion.
      send_byte(8'h55, 1'b1);
      wait_rdy("rdy_55");
      d = 8'hC3;
      exp_q.push_back({1'b0, d});
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      check("ovr_rdy_low", rdy, 0);
      check("ovr_old_data", rx_data, 8'h55);
      for (int i = 4; i < 8; i++) drive_bit(d[i]);
      drive_bit(1'b1);
      wait_rdy("rdy_c3");

      // Glitch shorter than half a bit: clears rdy, nothing received.
      RX = 1'b0;
      repeat (HALF / 2) @(posedge clk);
      #1;
      idle(B);
      check("glitch_rdy", rdy, 0);
      check("glitch_data", rx_data, 8'hC3);
      idle(B);

      // Framing error still presents the byte; next good byte clears frm_err.
      send_byte(8'h3C, 1'b0);
      wait_rdy("rdy_3c");
      check("ferr_set", frm_err, 1);
      pulse_clr("clr_3c");
      idle(2 * B);
      send_byte(8'h11, 1'b1);
      wait_rdy("rdy_11");
      check("ferr_cleared", frm_err, 0);
      pulse_clr("clr_11");
      idle(B);

      // clr_rdy held high across the set cycle: set must win.
      hs_seen = 1'b0;
      fork
         send_byte(8'h5A, 1'b1);
         begin
            clr_rdy = 1'b1;
            for (int i = 0; i < 12 * B && !hs_seen; i++) begin
               @(negedge clk);
               if (rdy) begin
                  clr_rdy = 1'b0;
                  hs_seen = 1'b1;
               end
            end
            clr_rdy = 1'b0;
         end
      join
      check("hs_rdy_seen", hs_seen, 1);
      repeat (3) @(negedge clk);
      check("hs_set_wins", rdy, 1);
      pulse_clr("hs_clr");
      idle(B);

      // Asynchronous reset during data bit 4 of 8'h96.
      d = 8'h96;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      RX = d[4];
      repeat (HALF) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_rdy", rdy, 0);
      check("rstmid_rx_data", rx_data, 8'h00);
      check("rstmid_frm_err", frm_err, 0);
      RX = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2 * B);
      send_byte(8'h96, 1'b1);
      wait_rdy("rdy_96");
      idle(B);

      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
